vending_fsm: RTL and testbench
==============================

# vending_fsm

Vending-machine control FSM that consumes the one-cycle press pulses produced by the per-button debounce filters. It keeps a coin credit, vends one of two products when the credit covers the price, and returns change one coin per cycle. It is the direct downstream consumer of the button filter stage and drives the dispense/change actuators and the credit display.

## Interface
- PRICE_A, 300, price of product A in won; multiple of 100, ≤ CREDIT_MAX
- PRICE_B, 500, price of product B in won; multiple of 100, ≤ CREDIT_MAX
- CREDIT_MAX, 2000, maximum credit held; multiple of 100, ≤ 4095
- VEND_CYCLES, 4, cycles the vend output is held high (≥ 1)
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- coin100  input  1  one-cycle pulse: 100-won coin inserted
- coin500  input  1  one-cycle pulse: 500-won coin inserted
- sel_a  input  1  one-cycle pulse: product A selected
- sel_b  input  1  one-cycle pulse: product B selected
- ret  input  1  one-cycle pulse: return-credit request
- credit  output  12  current credit in won
- vend_a  output  1  dispense product A; high for VEND_CYCLES cycles
- vend_b  output  1  dispense product B; high for VEND_CYCLES cycles
- chg100  output  1  eject one 100-won coin; high one cycle per coin
- chg500  output  1  eject one 500-won coin; high one cycle per coin
- coin_rej  output  1  one-cycle pulse: the coin sampled at the previous edge is returned, not credited
- deny  output  1  one-cycle pulse: selection refused for insufficient credit
- busy  output  1  high while in VEND or CHANGE

## Operation
- States: IDLE, VEND, CHANGE. On rst: state IDLE, credit 0, every output 0, vend hold counter 0.
- All outputs are registered. Inputs are sampled on the rising edge, and effects are visible in the following cycle.
- IDLE input priority in one cycle: ret > sel_a > sel_b > coin500 > coin100.
  - ret with credit > 0 goes to CHANGE. ret with credit = 0 is ignored and stays IDLE.
  - sel_x with credit ≥ PRICE_X: credit -= PRICE_X, vend_x = 1, load the hold counter with VEND_CYCLES, go to VEND.
  - sel_x with credit < PRICE_X: deny = 1 for one cycle. Credit is unchanged and the state stays IDLE.
  - A lower-priority select in the same cycle as a higher one is dropped silently.
  - A coin that is not the highest-priority event in its cycle is rejected (coin_rej = 1). This covers coin500 together with coin100: the 100 is rejected.
  - A coin that is accepted but would make credit + value > CREDIT_MAX is rejected, and credit is unchanged.
  - Otherwise credit += value.
- VEND: vend_x stays high and the counter decrements each cycle. When the counter expires, vend_x and busy clear at the same edge and the state returns to IDLE. Credit is kept for further purchases.
- CHANGE: one coin per edge.
  - If credit ≥ 500: chg500 = 1 and credit -= 500.
  - Else: chg100 = 1 and credit -= 100.
  - At the edge where credit reaches 0, go to IDLE. The chg pulse for that last coin is still emitted.
- In VEND and CHANGE, every coin pulse produces coin_rej, and sel_a/sel_b/ret are ignored.
- Widths: credit is 12-bit unsigned. Parameter constraints keep it a multiple of 100, so it never underflows or wraps.
- Reset mid-VEND or mid-CHANGE: immediate return to IDLE with credit 0. Remaining change is forfeited, which is accepted behaviour.

## Timing
- Coin sampled at edge E: credit updates after E, or coin_rej is high for cycle E..E+1.
- Select accepted at E: vend_x and busy are high from E to E+VEND_CYCLES, and low after edge E+VEND_CYCLES. The next IDLE sample is at E+VEND_CYCLES+1.
- ret at E: busy rises after E. Coin pulses are emitted after edges E+1 … E+n, where n = number of coins, and busy falls after E+n.
- chg pulses for consecutive coins are back-to-back. The actuator counts high cycles, not edges.
- deny and coin_rej are exactly one cycle wide. They never merge with each other, because the input pulses are one cycle wide.

## Test plan
- Reset, then coin500 and coin100 pulses at different cycles -> credit 500, then 600; no coin_rej.
- credit 600, sel_a -> credit 300 next cycle; vend_a and busy high exactly 4 cycles; coin100 during VEND gives coin_rej and credit stays 300.
- credit 200, sel_b -> deny one cycle; credit 200; vend_b never asserts.
- credit 800, ret -> chg500 one cycle, then chg100 three consecutive cycles; credit 300, 200, 100, 0; busy falls after the 4th coin; ret at credit 0 does nothing.
- credit 1800, coin500 -> coin_rej and credit stays 1800. Then coin100 and coin500 in the same cycle -> credit 2300 exceeds the max, so coin_rej fires and credit stays 1800.
- Simultaneous ret+sel_a+coin100 at credit 700 -> CHANGE taken, coin_rej, no vend. Assert rst after the first chg500 -> credit 0, all outputs 0 while rst is high.

Source files
------------

// File: rtl/vending_fsm.sv
// Vending-machine controller: holds coin credit, vends products A/B, and returns change one coin per cycle.
// All outputs are registered; inputs are single-cycle pulses from the button filters.
module vending_fsm #(
  parameter int PRICE_A     = 300,
  parameter int PRICE_B     = 500,
  parameter int CREDIT_MAX  = 2000,
  parameter int VEND_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin100,
  input  logic        coin500,
  input  logic        sel_a,
  input  logic        sel_b,
  input  logic        ret,
  output logic [11:0] credit,
  output logic        vend_a,
  output logic        vend_b,
  output logic        chg100,
  output logic        chg500,
  output logic        coin_rej,
  output logic        deny,
  output logic        busy
);

  // state  | meaning
  // IDLE   | accepting coins, selections and return requests
  // VEND   | dispensing; vend_x held until the hold counter expires
  // CHANGE | ejecting one coin per cycle until credit reaches 0
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  localparam int CW = $clog2(VEND_CYCLES + 1);
  localparam logic [11:0] PA   = 12'(PRICE_A);
  localparam logic [11:0] PB   = 12'(PRICE_B);
  localparam logic [12:0] CMAX = 13'(CREDIT_MAX);

  state_t          state, state_n;
  logic [11:0]     credit_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            vend_a_n, vend_b_n, chg100_n, chg500_n, coin_rej_n, deny_n, busy_n;
  logic [12:0]     sum500, sum100;

  assign sum500 = {1'b0, credit} + 13'd500;
  assign sum100 = {1'b0, credit} + 13'd100;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      credit   <= '0;
      cnt      <= '0;
      vend_a   <= 1'b0;
      vend_b   <= 1'b0;
      chg100   <= 1'b0;
      chg500   <= 1'b0;
      coin_rej <= 1'b0;
      deny     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      credit   <= credit_n;
      cnt      <= cnt_n;
      vend_a   <= vend_a_n;
      vend_b   <= vend_b_n;
      chg100   <= chg100_n;
      chg500   <= chg500_n;
      coin_rej <= coin_rej_n;
      deny     <= deny_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    credit_n   = credit;
    cnt_n      = cnt;
    vend_a_n   = 1'b0;
    vend_b_n   = 1'b0;
    chg100_n   = 1'b0;
    chg500_n   = 1'b0;
    coin_rej_n = 1'b0;
    deny_n     = 1'b0;
    case (state)
      IDLE: begin
        // Any coin that is not the top-priority event of the cycle is handed back.
        if (ret) begin
          coin_rej_n = coin500 | coin100;
          if (credit != 12'd0) state_n = CHANGE;
        end else if (sel_a) begin
          coin_rej_n = coin500 | coin100;
          if (credit >= PA) begin
            credit_n = credit - PA;
            vend_a_n = 1'b1;
            cnt_n    = CW'(VEND_CYCLES);
            state_n  = VEND;
          end else begin
            deny_n = 1'b1;
          end
        end else if (sel_b) begin
          coin_rej_n = coin500 | coin100;
          if (credit >= PB) begin
            credit_n = credit - PB;
            vend_b_n = 1'b1;
            cnt_n    = CW'(VEND_CYCLES);
            state_n  = VEND;
          end else begin
            deny_n = 1'b1;
          end
        end else if (coin500) begin
          coin_rej_n = coin100;
          if (sum500 > CMAX) coin_rej_n = 1'b1;
          else               credit_n   = sum500[11:0];
        end else if (coin100) begin
          if (sum100 > CMAX) coin_rej_n = 1'b1;
          else               credit_n   = sum100[11:0];
        end
      end
      VEND: begin
        coin_rej_n = coin500 | coin100;
        if (cnt <= CW'(1)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n    = cnt - CW'(1);
          vend_a_n = vend_a;
          vend_b_n = vend_b;
        end
      end
      CHANGE: begin
        coin_rej_n = coin500 | coin100;
        if (credit >= 12'd500) begin
          chg500_n = 1'b1;
          credit_n = credit - 12'd500;
        end else begin
          chg100_n = 1'b1;
          credit_n = credit - 12'd100;
        end
        if (credit_n == 12'd0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_vending_fsm.sv
// Directed self-checking bench for vending_fsm; inputs driven on the falling edge, outputs checked there too.
module tb_vending_fsm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coin100 = 1'b0, coin500 = 1'b0, sel_a = 1'b0, sel_b = 1'b0, ret = 1'b0;
  logic [11:0] credit;
  logic        vend_a, vend_b, chg100, chg500, coin_rej, deny, busy;
  int          passed = 0;
  int          total  = 0;

  localparam logic [4:0] P_RET = 5'b10000, P_SA = 5'b01000, P_SB = 5'b00100,
                         P_C5  = 5'b00010, P_C1 = 5'b00001;

  vending_fsm dut (
    .clk(clk), .rst(rst), .coin100(coin100), .coin500(coin500), .sel_a(sel_a),
    .sel_b(sel_b), .ret(ret), .credit(credit), .vend_a(vend_a), .vend_b(vend_b),
    .chg100(chg100), .chg500(chg500), .coin_rej(coin_rej), .deny(deny), .busy(busy)
  );

  always #5 clk = ~clk;

  wire [6:0] outs = {vend_a, vend_b, chg100, chg500, coin_rej, deny, busy};

  task automatic step();
    @(negedge clk);
  endtask

  // Drive one pulse across a single rising edge; returns at the falling edge after it.
  task automatic pulse(input logic [4:0] v);
    {ret, sel_a, sel_b, coin500, coin100} = v;
    @(negedge clk);
    {ret, sel_a, sel_b, coin500, coin100} = 5'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (credit !== 12'd0) $display("FAIL reset_credit got %0d want 0", credit);
    else passed++;
    total++;
    if (outs !== 7'b0) $display("FAIL reset_outs got %b want 0000000", outs);
    else passed++;
  endtask

  task automatic test_coins();
    pulse(P_C5);
    total++;
    if (credit !== 12'd500 || coin_rej !== 1'b0)
      $display("FAIL coin500 credit %0d rej %b want 500 0", credit, coin_rej);
    else passed++;
    step();
    pulse(P_C1);
    total++;
    if (credit !== 12'd600 || coin_rej !== 1'b0)
      $display("FAIL coin100 credit %0d rej %b want 600 0", credit, coin_rej);
    else passed++;
  endtask

  task automatic test_vend_a();
    int va_n = 0, bz_n = 0;
    pulse(P_SA);
    total++;
    if (credit !== 12'd300 || vend_a !== 1'b1 || busy !== 1'b1)
      $display("FAIL vend_a_start credit %0d vend_a %b busy %b want 300 1 1", credit, vend_a, busy);
    else passed++;
    va_n = 1; bz_n = 1;
    coin100 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      coin100 = 1'b0;
      if (i == 0) begin
        total++;
        if (coin_rej !== 1'b1 || credit !== 12'd300)
          $display("FAIL vend_coin_rej rej %b credit %0d want 1 300", coin_rej, credit);
        else passed++;
      end
      va_n += int'(vend_a);
      bz_n += int'(busy);
    end
    total++;
    if (va_n != 4 || bz_n != 4) $display("FAIL vend_a_len vend_a %0d busy %0d cycles want 4 4", va_n, bz_n);
    else passed++;
  endtask

  task automatic test_deny();
    int vb_n = 0;
    do_reset();
    pulse(P_C1);
    pulse(P_C1);
    pulse(P_SB);
    total++;
    if (deny !== 1'b1 || credit !== 12'd200 || vend_b !== 1'b0 || busy !== 1'b0)
      $display("FAIL deny_b deny %b credit %0d vend_b %b busy %b want 1 200 0 0", deny, credit, vend_b, busy);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      vb_n += int'(vend_b);
      if (i == 0) begin
        total++;
        if (deny !== 1'b0) $display("FAIL deny_width deny %b want 0", deny);
        else passed++;
      end
    end
    total++;
    if (vb_n != 0 || credit !== 12'd200) $display("FAIL deny_after vend_b %0d credit %0d want 0 200", vb_n, credit);
    else passed++;
  endtask

  task automatic test_change();
    logic [11:0] exp_cr [4] = '{12'd300, 12'd200, 12'd100, 12'd0};
    logic [1:0]  exp_cg [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
    do_reset();
    pulse(P_C5); pulse(P_C1); pulse(P_C1); pulse(P_C1);
    pulse(P_RET);
    total++;
    if (busy !== 1'b1 || credit !== 12'd800 || {chg100, chg500} !== 2'b00)
      $display("FAIL ret_start busy %b credit %0d chg %b want 1 800 00", busy, credit, {chg100, chg500});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (credit !== exp_cr[i] || {chg100, chg500} !== exp_cg[i] || busy !== (i < 3))
        $display("FAIL change_coin%0d credit %0d chg %b busy %b want %0d %b %b",
                 i, credit, {chg100, chg500}, busy, exp_cr[i], exp_cg[i], (i < 3));
      else passed++;
    end
    step();
    total++;
    if ({chg100, chg500, busy} !== 3'b000) $display("FAIL change_end chg/busy %b want 000", {chg100, chg500, busy});
    else passed++;
    pulse(P_RET);
    step();
    total++;
    if (outs !== 7'b0 || credit !== 12'd0) $display("FAIL ret_zero outs %b credit %0d want 0 0", outs, credit);
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    pulse(P_C5); pulse(P_C5); pulse(P_C5);
    pulse(P_C1); pulse(P_C1); pulse(P_C1);
    pulse(P_C5);
    total++;
    if (coin_rej !== 1'b1 || credit !== 12'd1800)
      $display("FAIL ovf_500 rej %b credit %0d want 1 1800", coin_rej, credit);
    else passed++;
    step();
    pulse(P_C5 | P_C1);
    total++;
    if (coin_rej !== 1'b1 || credit !== 12'd1800)
      $display("FAIL ovf_both rej %b credit %0d want 1 1800", coin_rej, credit);
    else passed++;
    step();
    pulse(P_C1);
    pulse(P_C1);
    total++;
    if (coin_rej !== 1'b0 || credit !== 12'd2000)
      $display("FAIL fill_max rej %b credit %0d want 0 2000", coin_rej, credit);
    else passed++;
    pulse(P_C1);
    total++;
    if (coin_rej !== 1'b1 || credit !== 12'd2000)
      $display("FAIL over_max rej %b credit %0d want 1 2000", coin_rej, credit);
    else passed++;
  endtask

  task automatic test_priority_reset();
    do_reset();
    pulse(P_C5); pulse(P_C1); pulse(P_C1);
    pulse(P_RET | P_SA | P_C1);
    total++;
    if (busy !== 1'b1 || coin_rej !== 1'b1 || vend_a !== 1'b0 || credit !== 12'd700)
      $display("FAIL prio busy %b rej %b vend_a %b credit %0d want 1 1 0 700", busy, coin_rej, vend_a, credit);
    else passed++;
    step();
    total++;
    if (chg500 !== 1'b1 || credit !== 12'd200)
      $display("FAIL prio_chg500 chg500 %b credit %0d want 1 200", chg500, credit);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (outs !== 7'b0 || credit !== 12'd0) $display("FAIL async_rst outs %b credit %0d want 0 0", outs, credit);
    else passed++;
    step();
    total++;
    if (outs !== 7'b0 || credit !== 12'd0) $display("FAIL rst_hold outs %b credit %0d want 0 0", outs, credit);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse(P_C5); pulse(P_C5);
    pulse(P_SB);
    total++;
    if (vend_b !== 1'b1 || credit !== 12'd500) $display("FAIL b2b_vend_b vend_b %b credit %0d want 1 500", vend_b, credit);
    else passed++;
    pulse(P_SA);
    total++;
    if (vend_a !== 1'b0 || credit !== 12'd500) $display("FAIL b2b_sel_ignored vend_a %b credit %0d want 0 500", vend_a, credit);
    else passed++;
    step(); step(); step();
    total++;
    if (vend_b !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_vend_end vend_b %b busy %b want 0 0", vend_b, busy);
    else passed++;
    pulse(P_SA);
    total++;
    if (vend_a !== 1'b1 || credit !== 12'd200) $display("FAIL b2b_vend_a vend_a %b credit %0d want 1 200", vend_a, credit);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_coins();
    test_vend_a();
    test_deny();
    test_change();
    test_overflow();
    test_priority_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
